// File: rtl/random_delay_pkg.sv
// Shared definitions for the random-delay round timer: FSM state codes and
// default sizing, also used by the referee FSM.
package random_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COUNT   = 2'd2,
        ST_FIRE    = 2'd3
    } rd_state_e;

    localparam int DEF_NBITS     = 4;
    localparam int DEF_MIN_TICKS = 2;

endpackage

// File: rtl/rand_bit_collector.sv
// Serial-to-parallel capture of the random bit stream; first captured bit ends up as MSB.
// value/done reflect the shift happening on this clk so the caller can load on the same tick.
module rand_bit_collector
    import random_delay_pkg::*;
#(
    parameter int NBITS = DEF_NBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             slowenable,
    input  logic             rin,
    output logic [NBITS-1:0] value,
    output logic             done
);

    localparam int BW = $clog2(NBITS + 1);

    logic [NBITS-1:0] shreg_q;
    logic [NBITS-1:0] shreg_d;
    logic [BW-1:0]    bitcnt_q;

    always_comb begin
        shreg_d = shreg_q;
        if (slowenable) begin
            shreg_d = {shreg_q[NBITS-2:0], rin};
        end
    end

    assign value = shreg_d;
    assign done  = slowenable && (bitcnt_q == BW'(NBITS - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else if (slowenable) begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_q + BW'(1);
        end
    end

endmodule

// File: rtl/random_delay.sv
// Round timer: collects NBITS random bits, then waits MIN_TICKS + R ticks and
// pulses go for one clock.
module random_delay
    import random_delay_pkg::*;
#(
    parameter int NBITS     = DEF_NBITS,
    parameter int MIN_TICKS = DEF_MIN_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slowenable,
    input  logic                rin,
    input  logic                start,
    input  logic                abort,
    output logic                go,
    output logic                busy,
    output logic [NBITS:0]      delay_q
);

    localparam int CW = NBITS + 1;

    rd_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [NBITS-1:0]  coll_value;
    logic              coll_done;
    logic [CW-1:0]     load_val;

    // Collector is held clear while idle, so a tick coinciding with start is dropped.
    rand_bit_collector #(
        .NBITS(NBITS)
    ) u_collector (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q == ST_IDLE),
        .slowenable (slowenable && (state_q == ST_COLLECT)),
        .rin        (rin),
        .value      (coll_value),
        .done       (coll_done)
    );

    assign load_val = CW'(MIN_TICKS) + CW'(coll_value);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            go      <= 1'b0;
            busy    <= 1'b0;
            delay_q <= '0;
        end else begin
            go <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q <= ST_COLLECT;
                        busy    <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (coll_done) begin
                        cnt_q   <= load_val;
                        delay_q <= load_val;
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (slowenable) begin
                        // Counting down through zero makes the wait D+1 ticks.
                        if (cnt_q == '0) begin
                            state_q <= ST_FIRE;
                            go      <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                ST_FIRE: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_delay.sv
// Directed bench for random_delay (NBITS=4, MIN_TICKS=2, one tick every 4 clocks).
module tb_random_delay;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       slowenable = 1'b0;
    logic       rin = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       go;
    logic       busy;
    logic [4:0] delay_q;

    int checks = 0;
    int errors = 0;
    int ticks = 0;
    int phase = 0;
    int go_cnt = 0;
    logic counting = 1'b0;
    logic ticks_on = 1'b1;
    logic [3:0] rseq = 4'h0;

    localparam int LIMIT = 600;

    typedef struct {
        logic [3:0] seq;
        int         exp_delay;
        int         exp_ticks;
    } vec_t;

    vec_t vecs[5];

    random_delay dut (
        .clk        (clk),
        .rst        (rst),
        .slowenable (slowenable),
        .rin        (rin),
        .start      (start),
        .abort      (abort),
        .go         (go),
        .busy       (busy),
        .delay_q    (delay_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // One clock: count the tick the edge consumed, then set up the next cycle's inputs.
    task automatic tick();
        @(posedge clk);
        if (slowenable && counting) ticks++;
        #1;
        if (go) go_cnt++;
        phase = (phase + 1) % 4;
        slowenable = ticks_on && (phase == 0);
        rin = (ticks < 4) ? rseq[3 - ticks] : ticks[0];
    endtask

    task automatic begin_round(input logic [3:0] seq);
        rseq = seq;
        ticks = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        counting = 1'b1;
    endtask

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (ticks < n && k < LIMIT) begin
            tick();
            k++;
        end
        if (ticks < n) check("wait_ticks_timeout", ticks, n);
    endtask

    task automatic finish_round(input string nm, input int exp_d, input int exp_t, input int restart_at);
        int k;
        k = 0;
        while (!go && k < LIMIT) begin
            if (ticks == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
            k++;
        end
        check({nm, "_go_seen"}, int'(go), 1);
        check({nm, "_ticks"}, ticks, exp_t);
        check({nm, "_delay"}, int'(delay_q), exp_d);
        tick();
        check({nm, "_go_width"}, int'(go), 0);
        check({nm, "_busy_after"}, int'(busy), 0);
        counting = 1'b0;
    endtask

    task automatic abort_at(input string nm, input logic [3:0] seq, input int at, input int exp_d);
        int g0;
        begin_round(seq);
        wait_ticks(at);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        counting = 1'b0;
        check({nm, "_busy"}, int'(busy), 0);
        check({nm, "_delay"}, int'(delay_q), exp_d);
        g0 = go_cnt;
        repeat (100) tick();
        check({nm, "_no_go"}, go_cnt, g0);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 17, 22};
        vecs[1] = '{4'b0000,  2,  7};
        vecs[2] = '{4'b1011, 13, 18};
        vecs[3] = '{4'b0110,  8, 13};
        vecs[4] = '{4'b1000, 10, 15};

        rst = 1'b0;
        repeat (3) tick();
        check("reset_go", int'(go), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_delay", int'(delay_q), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            begin_round(vecs[i].seq);
            check($sformatf("vec%0d_busy", i), int'(busy), 1);
            finish_round($sformatf("vec%0d", i), vecs[i].exp_delay, vecs[i].exp_ticks, -1);
            repeat (3) tick();
        end

        // Aborts: in COLLECT the last delay is kept; in COUNT the new delay was already loaded.
        abort_at("abort_collect", 4'b1111, 2, 10);
        abort_at("abort_count", 4'b1111, 9, 17);

        // Reset in the middle of a countdown.
        begin_round(4'b1111);
        wait_ticks(7);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        counting = 1'b0;
        check("rst_mid_go", int'(go), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_delay", int'(delay_q), 0);
        repeat (2) tick();

        // start re-asserted while busy must not disturb timing.
        begin_round(4'b0000);
        finish_round("start_busy", 2, 7, 3);
        repeat (2) tick();

        // start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        check("start_abort_busy0", int'(busy), 0);
        tick();
        check("start_abort_busy1", int'(busy), 0);
        start = 1'b0;
        abort = 1'b0;
        tick();

        // Ticks stall mid-round, then resume.
        begin
            int g0;
            begin_round(4'b0000);
            wait_ticks(5);
            ticks_on = 1'b0;
            slowenable = 1'b0;
            g0 = go_cnt;
            repeat (60) tick();
            check("stall_busy", int'(busy), 1);
            check("stall_no_go", go_cnt, g0);
            ticks_on = 1'b1;
            finish_round("stall_resume", 2, 7, -1);
        end

        // start held high: IDLE for one clock after FIRE, then a new round begins.
        rseq = 4'b0000;
        ticks = 0;
        start = 1'b1;
        tick();
        counting = 1'b1;
        begin
            int k;
            k = 0;
            while (!go && k < LIMIT) begin
                tick();
                k++;
            end
        end
        check("held_ticks", ticks, 7);
        tick();
        check("held_idle_busy", int'(busy), 0);
        tick();
        check("held_restart_busy", int'(busy), 1);
        start = 1'b0;
        counting = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("held_abort_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
